// File: rtl/l2_shared_port_arbiter.sv
// l2_shared_port_arbiter: round-robin owner of the single L2 request port,
// shared by two L1 cache controllers (L1a, L1b).
// Ports:
//   clk, reset                   clock, async active-high reset
//   l1{a,b}_{rd,wr,wb}_req       level requests, held until l1x_done
//   l1{a,b}_addr/wr_word/wb_line request payload
//   l1{a,b}_done, l1{a,b}_rd_line  completion pulse and fill data to the owner
//   l2_{rd,wr,wb}_req, l2_addr, l2_wr_word, l2_wb_line  registered L2 request
//   l2_rd_done, l2_rd_line, l2_wr_done, l2_wb_done     L2 completion
//   owner, busy, timeout_err     status
module l2_shared_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int WORD_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              l1a_rd_req,
    input  logic              l1a_wr_req,
    input  logic              l1a_wb_req,
    input  logic [ADDR_W-1:0] l1a_addr,
    input  logic [WORD_W-1:0] l1a_wr_word,
    input  logic [LINE_W-1:0] l1a_wb_line,
    output logic              l1a_done,
    output logic [LINE_W-1:0] l1a_rd_line,
    input  logic              l1b_rd_req,
    input  logic              l1b_wr_req,
    input  logic              l1b_wb_req,
    input  logic [ADDR_W-1:0] l1b_addr,
    input  logic [WORD_W-1:0] l1b_wr_word,
    input  logic [LINE_W-1:0] l1b_wb_line,
    output logic              l1b_done,
    output logic [LINE_W-1:0] l1b_rd_line,
    output logic              l2_rd_req,
    output logic              l2_wr_req,
    output logic              l2_wb_req,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [WORD_W-1:0] l2_wr_word,
    output logic [LINE_W-1:0] l2_wb_line,
    input  logic              l2_rd_done,
    input  logic [LINE_W-1:0] l2_rd_line,
    input  logic              l2_wr_done,
    input  logic              l2_wb_done,
    output logic              owner,
    output logic              busy,
    output logic              timeout_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    // Counter value seen in the last WAIT cycle before giving up.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic              r_rr;
    logic              r_owner;
    // One-hot op, bit 2 = wb, bit 1 = wr, bit 0 = rd; drives the L2 request lines.
    logic [2:0]        r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_word;
    logic [LINE_W-1:0] r_line;
    logic [15:0]       r_cnt;
    logic              r_err;
    logic              r_a_done;
    logic              r_b_done;
    logic [LINE_W-1:0] r_a_line;
    logic [LINE_W-1:0] r_b_line;

    logic       w_a_act;
    logic       w_b_act;
    logic       w_pick_b;
    logic       w_grant;
    logic [2:0] w_ops;
    logic [2:0] w_op;
    logic       w_cmp;
    logic       w_to;
    logic       w_end;

    assign w_a_act  = l1a_rd_req | l1a_wr_req | l1a_wb_req;
    assign w_b_act  = l1b_rd_req | l1b_wr_req | l1b_wb_req;
    // L1b wins when it is the only requester or the rr pointer favours it.
    assign w_pick_b = w_b_act & (~w_a_act | r_rr);
    assign w_grant  = (r_state == S_IDLE) & (w_a_act | w_b_act);

    assign w_ops = w_pick_b ? {l1b_wb_req, l1b_wr_req, l1b_rd_req}
                            : {l1a_wb_req, l1a_wr_req, l1a_rd_req};

    always_comb begin
        w_op = 3'b000;
        if (w_ops[2])      w_op = 3'b100;
        else if (w_ops[1]) w_op = 3'b010;
        else if (w_ops[0]) w_op = 3'b001;
    end

    // Only the done strobe matching the latched op completes the transaction.
    assign w_cmp = (r_state == S_WAIT) &
                   (|(r_req & {l2_wb_done, l2_wr_done, l2_rd_done}));
    // A real completion in the final cycle takes precedence over the timeout.
    assign w_to  = (r_state == S_WAIT) & ~w_cmp & (r_cnt == TO_LAST);
    assign w_end = w_cmp | w_to;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rr     <= 1'b0;
            r_owner  <= 1'b0;
            r_req    <= 3'b000;
            r_addr   <= '0;
            r_word   <= '0;
            r_line   <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            r_a_line <= '0;
            r_b_line <= '0;
        end else begin
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            r_a_line <= '0;
            r_b_line <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_pick_b;
                        r_req   <= w_op;
                        r_addr  <= w_pick_b ? l1b_addr : l1a_addr;
                        r_word  <= w_pick_b ? l1b_wr_word : l1a_wr_word;
                        r_line  <= w_pick_b ? l1b_wb_line : l1a_wb_line;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_end) begin
                        r_req    <= 3'b000;
                        r_rr     <= ~r_owner;
                        r_a_done <= ~r_owner;
                        r_b_done <= r_owner;
                        r_state  <= S_REL;
                        if (w_to) r_err <= 1'b1;
                        // Fill data goes to the owner only; a timeout returns zero.
                        if (w_cmp && r_req[0]) begin
                            if (r_owner) r_b_line <= l2_rd_line;
                            else         r_a_line <= l2_rd_line;
                        end
                    end
                end
                S_REL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign l2_rd_req   = r_req[0];
    assign l2_wr_req   = r_req[1];
    assign l2_wb_req   = r_req[2];
    assign l2_addr     = r_addr;
    assign l2_wr_word  = r_word;
    assign l2_wb_line  = r_line;
    assign l1a_done    = r_a_done;
    assign l1b_done    = r_b_done;
    assign l1a_rd_line = r_a_line;
    assign l1b_rd_line = r_b_line;
    assign owner       = r_owner;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_err;

endmodule
